uart_tx: RTL
============

Name: uart_tx

Overview:
- 8-bit asynchronous serial transmitter: the transmit end of the board's UART link, the counterpart of the existing 8x-oversampling receiver.
- Frame format: 1 start bit (0), 8 data bits LSB first, optional parity bit, 1 stop bit (1).
- Baud timing comes from an internal divider counting system-clock cycles.
- A one-entry holding register lets the next byte be queued while the current frame shifts out, so back-to-back frames have zero idle gap.

Parameters:
- CLK_DIV, 625, system clocks per bit period (48 MHz / 625 = 76800 baud); legal range 2..65535.
- PARITY_EN, 1, 1 = parity bit inserted after the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity; 1 = odd parity. Ignored when PARITY_EN = 0.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send; sampled only on an accept.
- tx_valid  input  1  the producer has a byte on tx_data.
- tx_ready  output  1  the holding register is empty and a byte can be accepted.
- data_out  output  1  serial line; idles high.
- tx_busy  output  1  a frame is on the line (any state other than IDLE).
- parity_led  output  1  parity bit of the most recently started frame; 0 when PARITY_EN = 0.

Behaviour:
- Reset, sampled on the CLK edge with RST = 1:
  - data_out = 1, tx_ready = 1, tx_busy = 0, parity_led = 0.
  - Holding register emptied, state = IDLE, baud counter and bit index = 0.
  - A reset mid-frame aborts the frame; the line is high on the next edge. No partial-frame recovery.
- Accept:
  - An accept occurs on any edge with tx_valid && tx_ready.
  - tx_data is latched into the holding register, which becomes full; tx_ready drops on the next edge.
  - tx_valid while tx_ready = 0 is ignored; the producer holds its data.
- State machine: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE or START.
  - Every state except IDLE lasts exactly CLK_DIV cycles.
  - The baud counter runs 0..CLK_DIV-1 and is cleared on each state or bit change.
- IDLE:
  - If the holding register is full, move it to the shift register and empty it.
  - Compute parity as the XOR of all 8 bits, inverted when PARITY_ODD = 1.
  - Update parity_led, then go to START.
  - Latency: accept on edge N with the block idle; the transfer happens on edge N+1; data_out = 0 from edge N+2.
  - tx_ready returns high on edge N+2.
- START: data_out = 0.
- DATA:
  - data_out = shift_reg[bit_idx], with bit_idx 0..7 (LSB first).
  - bit_idx advances at each bit-period end; after bit 7, go to PARITY or STOP.
- PARITY: data_out = computed parity bit.
- STOP: data_out = 1. At the end of the stop period:
  - Holding register full: load it, update parity_led, empty it, go directly to START. No idle cycle; the next start bit begins on the following edge.
  - Holding register empty: go to IDLE.
- Frame length: (10 + PARITY_EN) * CLK_DIV cycles.
- tx_busy = 1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Simultaneous accept and holding-register unload on the same edge cannot occur, because accepts require the register to be empty. An accept on the edge STOP ends is taken into the register and sent after the next IDLE pass (one extra cycle).
- The baud counter must be wide enough for CLK_DIV-1; the bit index is 3 bits.

Test Plan:
- Reset with CLK_DIV = 4:
  - Stimulus: RST = 1 for 3 cycles, then hold tx_valid = 0.
  - Required: data_out = 1, tx_ready = 1, tx_busy = 0, parity_led = 0 throughout.
- Single frame of 0x55, even parity, CLK_DIV = 4:
  - Line sequence, each bit 4 cycles: 0, 1,0,1,0,1,0,1,0, parity 0, stop 1.
  - Total 44 cycles with tx_busy = 1; parity_led = 0.
- 0xA7 with PARITY_ODD = 1, then with PARITY_ODD = 0:
  - Data bits LSB first: 1,1,1,0,0,1,0,1.
  - Parity bit = 0 for odd, 1 for even; parity_led matches.
- Back-to-back 0x0F then 0xF0, both accepted while busy:
  - The second accept happens once tx_ready reasserts.
  - The stop bit of frame 1 is followed immediately by the start bit of frame 2, with no high gap beyond 1 bit period.
  - tx_ready stays low while the register is full.
- PARITY_EN = 0, byte 0x81:
  - Frame is 10 bit periods: 0, 1,0,0,0,0,0,0,1, 1.
  - parity_led = 0.
- RST asserted during data bit 3 of 0x3C:
  - data_out = 1 on the next edge; tx_ready = 1, tx_busy = 0.
  - A new accept of 0x12 afterwards produces a clean, complete frame.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8-bit asynchronous serial transmitter with a one-entry holding
// register. Frame: start(0), 8 data bits LSB first, optional parity, stop(1).
// data_out, tx_busy and tx_ready are registered, so the line trails the FSM
// state by one clock. Every bit period therefore lasts exactly CLK_DIV cycles,
// and back-to-back frames butt together with no gap.
module uart_tx #(
  parameter int CLK_DIV    = 625,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       data_out,
  output logic       tx_busy,
  output logic       parity_led
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] BAUD_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BAUD_ONE = CW'(1);
  localparam logic          PAR_EN   = (PARITY_EN != 0);
  localparam logic          PAR_ODD  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_bit_q, par_bit_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          led_q, led_d;
  logic          dout_q, dout_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic baud_end;
  logic load;
  logic accept;

  // Next-state, holding-register and line-output logic.
  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_bit_d   = par_bit_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    led_d       = led_q;
    dout_d      = 1'b1;
    load        = 1'b0;
    baud_end    = (baud_q == BAUD_MAX);
    accept      = tx_valid && ready_q;
    busy_d      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        dout_d = 1'b1;
        baud_d = '0;
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        dout_d = 1'b0;
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_DATA: begin
        dout_d = shift_q[bit_idx_q];
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = 3'd0;
            state_d   = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_PARITY: begin
        dout_d = par_bit_q;
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_STOP: begin
        dout_d = 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase

    // Loading and accepting are mutually exclusive: accept needs an empty register.
    if (load) begin
      shift_d     = hold_q;
      par_bit_d   = (^hold_q) ^ PAR_ODD;
      led_d       = PAR_EN ? ((^hold_q) ^ PAR_ODD) : 1'b0;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    // Held low on the unload edge so ready reappears together with the start bit.
    ready_d = !hold_full_d && !load;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_bit_q   <= 1'b0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      led_q       <= 1'b0;
      dout_q      <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_bit_q   <= par_bit_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      led_q       <= led_d;
      dout_q      <= dout_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_ready   = ready_q;
  assign data_out   = dout_q;
  assign tx_busy    = busy_q;
  assign parity_led = led_q;

endmodule
